// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - dcache request/response bus between memory stage and dcache
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_byte_enable;
    logic [DATA_W-1:0]   mem_rdata;
    logic                dcache_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  mem_rdata, dcache_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output mem_rdata, dcache_resp
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - LC-3b memory-stage controller (loads/stores, byte, LDI/STI)
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              op_read,
    input  logic              op_write,
    input  logic              op_byte,
    input  logic              op_indirect,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [2:0]        dr_in,
    mem_stage_ctrl_if.master  dc,
    output logic              mem_stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic [2:0]        dr_out,
    output logic              err_out
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q, ptr_q, eff_addr;
    logic [DATA_W-1:0] wdata_q, rd_shift, load_data;
    logic [2:0]        dr_q;
    logic              byte_q, ind_q, write_q;
    logic [LB-1:0]     lane;
    logic              accept, in_flight, timed_out;

    assign accept    = valid_in && (op_read || op_write);
    assign in_flight = (state == PTR) || (state == ACCESS);
    assign eff_addr  = (state == ACCESS && ind_q) ? ptr_q : addr_q;
    assign lane      = eff_addr[LB-1:0];
    assign rd_shift  = dc.mem_rdata >> {lane, 3'b000};
    assign load_data = byte_q ? {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]} : dc.mem_rdata;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;

    assign timed_out = in_flight && (tmo_cnt == CW'(TIMEOUT_CYC));

    // Counter restarts on every state change, so each phase of LDI/STI gets its own budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_out <= 1'b0;
        end else begin
            if (state_nx != state)
                tmo_cnt <= '0;
            else if (in_flight && !dc.dcache_resp)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (timed_out)
                err_out <= 1'b1;
            else if (state == DONE)
                err_out <= 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_out   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = op_indirect ? PTR : ACCESS;
            PTR:     if (timed_out) state_nx = DONE;
                     else if (dc.dcache_resp) state_nx = ACCESS;
            ACCESS:  if (timed_out || dc.dcache_resp) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dc.mem_address     = '0;
        dc.mem_read        = 1'b0;
        dc.mem_write       = 1'b0;
        dc.mem_wdata       = '0;
        dc.mem_byte_enable = '0;
        mem_stall          = 1'b0;
        case (state)
            IDLE: mem_stall = accept;
            PTR: begin
                mem_stall          = 1'b1;
                dc.mem_read        = !timed_out;
                dc.mem_address     = addr_q & WORD_MASK;
                dc.mem_byte_enable = '1;
            end
            ACCESS: begin
                mem_stall          = 1'b1;
                dc.mem_read        = !write_q && !timed_out;
                dc.mem_write       = write_q && !timed_out;
                dc.mem_address     = byte_q ? eff_addr : (eff_addr & WORD_MASK);
                dc.mem_wdata       = byte_q ? {NB{wdata_q[7:0]}} : wdata_q;
                dc.mem_byte_enable = byte_q ? (NB'(1) << lane) : '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            rdata_out <= '0;
            dr_out    <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            wdata_q   <= '0;
            dr_q      <= '0;
            byte_q    <= 1'b0;
            ind_q     <= 1'b0;
            write_q   <= 1'b0;
        end else if (timed_out) begin
            valid_out <= 1'b1;
            rdata_out <= '0;
            dr_out    <= dr_q;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= addr_in;
                        wdata_q   <= wdata_in;
                        dr_q      <= dr_in;
                        byte_q    <= op_byte;
                        ind_q     <= op_indirect;
                        write_q   <= op_write;
                        valid_out <= 1'b0;
                    end else begin
                        valid_out <= valid_in;
                        if (valid_in) begin
                            rdata_out <= wdata_in;
                            dr_out    <= dr_in;
                        end
                    end
                end
                PTR: if (dc.dcache_resp) ptr_q <= ADDR_W'(dc.mem_rdata);
                ACCESS: begin
                    if (dc.dcache_resp) begin
                        valid_out <= 1'b1;
                        dr_out    <= dr_q;
                        rdata_out <= write_q ? wdata_q : load_data;
                    end
                end
                default: valid_out <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0, op_read = 1'b0, op_write = 1'b0, op_byte = 1'b0, op_indirect = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic [2:0]    dr_in = '0;
    logic          mem_stall, valid_out, err_out;
    logic [DW-1:0] rdata_out;
    logic [2:0]    dr_out;

    int checks = 0;
    int failures = 0;

    mem_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) dc();

    mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op_read(op_read), .op_write(op_write),
        .op_byte(op_byte), .op_indirect(op_indirect), .addr_in(addr_in), .wdata_in(wdata_in),
        .dr_in(dr_in), .dc(dc), .mem_stall(mem_stall), .valid_out(valid_out),
        .rdata_out(rdata_out), .dr_out(dr_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    int            stall_cnt, req_cnt, rd_cyc, wr_cyc;
    logic          done, early_req, done_stall, post_valid, post_stall, post_err, res_err;
    logic [AW-1:0] addr_obs [2];
    logic [1:0]    be_obs [2];
    logic [DW-1:0] wd_obs [2];
    logic [DW-1:0] res_data;
    logic [2:0]    res_dr;

    // Plays EX (holds the instruction while stalled) and the dcache (answers request k after wk wait cycles).
    task automatic run_op(input logic rd, input logic wr, input logic byt, input logic ind,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [2:0] dr,
                          input int w0, input logic [DW-1:0] d0, input int w1, input logic [DW-1:0] d1);
        int   run;
        logic fresh;
        stall_cnt = 0; req_cnt = 0; rd_cyc = 0; wr_cyc = 0; done = 1'b0; run = 0; fresh = 1'b1;
        res_data = '0; res_dr = '0; res_err = 1'b0; done_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin addr_obs[i] = '0; be_obs[i] = '0; wd_obs[i] = '0; end
        @(negedge clk);
        valid_in = 1'b1; op_read = rd; op_write = wr; op_byte = byt; op_indirect = ind;
        addr_in = a; wdata_in = wd; dr_in = dr;
        #1;
        if (mem_stall) stall_cnt++;
        early_req = dc.mem_read | dc.mem_write;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dc.dcache_resp = 1'b0;
            if (valid_out) begin
                done = 1'b1; res_data = rdata_out; res_dr = dr_out; res_err = err_out; done_stall = mem_stall;
            end else begin
                if (mem_stall) stall_cnt++;
                if (dc.mem_read || dc.mem_write) begin
                    if (fresh) begin
                        if (req_cnt < 2) begin
                            addr_obs[req_cnt] = dc.mem_address;
                            be_obs[req_cnt]   = dc.mem_byte_enable;
                            wd_obs[req_cnt]   = dc.mem_wdata;
                        end
                        req_cnt++; fresh = 1'b0; run = 0;
                    end
                    run++;
                    if (dc.mem_read) rd_cyc++;
                    if (dc.mem_write) wr_cyc++;
                    if (run == ((req_cnt == 1) ? w0 : w1) + 1) begin
                        dc.dcache_resp = 1'b1;
                        dc.mem_rdata = (req_cnt == 1) ? d0 : d1;
                        fresh = 1'b1;
                    end
                end
            end
        end
        dc.dcache_resp = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0; op_read = 1'b0; op_write = 1'b0; op_byte = 1'b0; op_indirect = 1'b0;
        @(negedge clk);
        post_valid = valid_out; post_stall = mem_stall; post_err = err_out;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        checks++; if (rdata_out !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", rdata_out); end
        checks++; if (dr_out !== 3'd0) begin failures++; $display("FAIL rst_dr got=%0d exp=0", dr_out); end
        checks++; if ({mem_stall, dc.mem_read, dc.mem_write, err_out} !== 4'b0000) begin failures++; $display("FAIL rst_ctl got=%b exp=0000", {mem_stall, dc.mem_read, dc.mem_write, err_out}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_non_mem;
        @(negedge clk);
        valid_in = 1'b1; wdata_in = 16'h1234; dr_in = 3'd5;
        #1;
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL nonmem_stall got=%b exp=0", mem_stall); end
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if ({valid_out, rdata_out, dr_out, mem_stall} !== {1'b1, 16'h1234, 3'd5, 1'b0}) begin failures++; $display("FAIL nonmem_out got=%b/%h/%0d/%b exp=1/1234/5/0", valid_out, rdata_out, dr_out, mem_stall); end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL nonmem_drop got=%b exp=0", valid_out); end
    endtask

    task automatic test_ldr_word;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 3'd2, 3, 16'hBEEF, 0, 16'h0000);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ldr_done got=%b exp=1", done); end
        checks++; if (early_req !== 1'b0) begin failures++; $display("FAIL ldr_early_req got=%b exp=0", early_req); end
        checks++; if (addr_obs[0] !== 16'h3000) begin failures++; $display("FAIL ldr_addr got=%h exp=3000", addr_obs[0]); end
        checks++; if (be_obs[0] !== 2'b11) begin failures++; $display("FAIL ldr_be got=%b exp=11", be_obs[0]); end
        checks++; if ({res_data, res_dr} !== {16'hBEEF, 3'd2}) begin failures++; $display("FAIL ldr_result got=%h/%0d exp=beef/2", res_data, res_dr); end
        checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL ldr_stall_cycles got=%0d exp=5", stall_cnt); end
        checks++; if ({done_stall, post_valid, post_stall} !== 3'b000) begin failures++; $display("FAIL ldr_retire got=%b exp=000", {done_stall, post_valid, post_stall}); end
    endtask

    task automatic test_byte;
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h2001, 16'h0000, 3'd3, 0, 16'h80FF, 0, 16'h0000);
        checks++; if ({addr_obs[0], be_obs[0]} !== {16'h2001, 2'b10}) begin failures++; $display("FAIL ldb_hi_req got=%h/%b exp=2001/10", addr_obs[0], be_obs[0]); end
        checks++; if (res_data !== 16'hFF80) begin failures++; $display("FAIL ldb_hi_data got=%h exp=ff80", res_data); end
        checks++; if (stall_cnt !== 2) begin failures++; $display("FAIL ldb_stall_cycles got=%0d exp=2", stall_cnt); end
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 3'd3, 1, 16'h7F01, 0, 16'h0000);
        checks++; if ({be_obs[0], res_data} !== {2'b01, 16'h0001}) begin failures++; $display("FAIL ldb_lo got=%b/%h exp=01/0001", be_obs[0], res_data); end
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h2003, 16'h0000, 3'd3, 0, 16'h7F01, 0, 16'h0000);
        checks++; if (res_data !== 16'h007F) begin failures++; $display("FAIL ldb_pos got=%h exp=007f", res_data); end
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h00AB, 3'd1, 1, 16'h0000, 0, 16'h0000);
        checks++; if ({wd_obs[0], be_obs[0]} !== {16'hABAB, 2'b01}) begin failures++; $display("FAIL stb_lanes got=%h/%b exp=abab/01", wd_obs[0], be_obs[0]); end
        checks++; if ({wr_cyc, rd_cyc} !== {32'd2, 32'd0}) begin failures++; $display("FAIL stb_strobes got=%0d/%0d exp=2/0", wr_cyc, rd_cyc); end
        checks++; if ({early_req, post_stall} !== 2'b00) begin failures++; $display("FAIL stb_write_outside got=%b exp=00", {early_req, post_stall}); end
        checks++; if (res_data !== 16'h00AB) begin failures++; $display("FAIL stb_result got=%h exp=00ab", res_data); end
    endtask

    task automatic test_indirect;
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 16'h0000, 3'd6, 1, 16'h6002, 2, 16'h0042);
        checks++; if (req_cnt !== 2) begin failures++; $display("FAIL ldi_requests got=%0d exp=2", req_cnt); end
        checks++; if ({addr_obs[0], addr_obs[1]} !== {16'h5000, 16'h6002}) begin failures++; $display("FAIL ldi_addrs got=%h/%h exp=5000/6002", addr_obs[0], addr_obs[1]); end
        checks++; if ({res_data, res_dr} !== {16'h0042, 3'd6}) begin failures++; $display("FAIL ldi_result got=%h/%0d exp=0042/6", res_data, res_dr); end
        checks++; if (stall_cnt !== 6) begin failures++; $display("FAIL ldi_stall_cycles got=%0d exp=6", stall_cnt); end
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h5001, 16'h5A5A, 3'd4, 0, 16'h7003, 0, 16'h0000);
        checks++; if ({addr_obs[0], addr_obs[1]} !== {16'h5000, 16'h7002}) begin failures++; $display("FAIL sti_addrs got=%h/%h exp=5000/7002", addr_obs[0], addr_obs[1]); end
        checks++; if ({rd_cyc, wr_cyc} !== {32'd1, 32'd1}) begin failures++; $display("FAIL sti_strobes got=%0d/%0d exp=1/1", rd_cyc, wr_cyc); end
        checks++; if ({wd_obs[1], be_obs[1], res_data} !== {16'h5A5A, 2'b11, 16'h5A5A}) begin failures++; $display("FAIL sti_data got=%h/%b/%h exp=5a5a/11/5a5a", wd_obs[1], be_obs[1], res_data); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        valid_in = 1'b1; wdata_in = 16'h1111; dr_in = 3'd1;
        @(negedge clk);
        checks++; if ({valid_out, rdata_out, dr_out} !== {1'b1, 16'h1111, 3'd1}) begin failures++; $display("FAIL b2b_first got=%b/%h/%0d exp=1/1111/1", valid_out, rdata_out, dr_out); end
        wdata_in = 16'h2222; dr_in = 3'd2;
        @(negedge clk);
        checks++; if ({valid_out, rdata_out, dr_out} !== {1'b1, 16'h2222, 3'd2}) begin failures++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/2222/2", valid_out, rdata_out, dr_out); end
        valid_in = 1'b0; dc.dcache_resp = 1'b1; dc.mem_rdata = 16'hDEAD;
        @(negedge clk);
        dc.dcache_resp = 1'b0;
        checks++; if ({valid_out, mem_stall, rdata_out} !== {1'b0, 1'b0, 16'h2222}) begin failures++; $display("FAIL idle_resp got=%b/%b/%h exp=0/0/2222", valid_out, mem_stall, rdata_out); end
    endtask

    task automatic test_reset_in_access;
        @(negedge clk);
        valid_in = 1'b1; op_read = 1'b1; addr_in = 16'h3000; dr_in = 3'd7;
        @(negedge clk);
        checks++; if (dc.mem_read !== 1'b1) begin failures++; $display("FAIL arst_pre_read got=%b exp=1", dc.mem_read); end
        rst_n = 1'b0; valid_in = 1'b0; op_read = 1'b0;
        #1;
        checks++; if ({dc.mem_read, mem_stall} !== 2'b00) begin failures++; $display("FAIL arst_drop got=%b exp=00", {dc.mem_read, mem_stall}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({valid_out, mem_stall, dc.mem_read} !== 3'b000) begin failures++; $display("FAIL arst_idle got=%b exp=000", {valid_out, mem_stall, dc.mem_read}); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 3'd3, 1000, 16'h0000, 0, 16'h0000);
        checks++; if ({done, res_err, res_data} !== {1'b1, 1'b1, 16'h0000}) begin failures++; $display("FAIL tmo_result got=%b/%b/%h exp=1/1/0000", done, res_err, res_data); end
        checks++; if (rd_cyc !== 4) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=4", rd_cyc); end
        checks++; if (post_err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear got=%b exp=0", post_err); end
    endtask
`endif

    initial begin
        dc.dcache_resp = 1'b0;
        dc.mem_rdata = '0;
        test_reset();
        test_non_mem();
        test_ldr_word();
        test_byte();
        test_indirect();
        test_back_to_back();
        test_reset_in_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
